// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the N-requester bus arbiter:
//   - state_t     : grant FSM encoding (IDLE, WAIT_BA, XFER)
//   - ARB_FIXED / ARB_RR : arbitration policy selectors
//   - LOCK_MAX    : longest run of back-to-back locked transfers
//   - idx_w()     : width of an owner index for n requesters
// ---------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_BA = 2'd1,
    XFER    = 2'd2
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int LOCK_MAX  = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_rr_picker.sv
// ---------------------------------------------------------------------------
// bus_rr_picker
// Combinational N-way priority picker.
//   req     in  N    request vector
//   ptr     in  IW   last owner; round-robin search starts at ptr+1
//   rr_mode in  1    0 = fixed priority (lowest index wins), 1 = round-robin
//   gnt     out N    one-hot winner (all zero when no request)
//   idx     out IW   index of the winner (0 when no request)
// ---------------------------------------------------------------------------
module bus_rr_picker
  import bus_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          rr_mode,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Walk the priority order from lowest to highest so the last hit, which is
  // the highest-priority requester, is the one left standing.
  always_comb begin
    int            j_int;
    logic [IW-1:0] j;
    gnt   = '0;
    idx   = '0;
    j_int = 0;
    j     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j_int = rr_mode ? (int'(ptr) + 1 + i) : i;
      if (j_int >= N) j_int = j_int - N;
      j = IW'(j_int);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_n.sv
// ---------------------------------------------------------------------------
// bus_arbiter_n
// Arbitrates N local masters (0 = core, 1..N-1 = DMA/others) onto the shared
// system bus and negotiates ownership with the system through BR/BA.
//
// Ports
//   CLK, RST   clock / synchronous active-high reset
//   D, A       system data / address bus (tri-state)
//   RW, FI, DT read(1)/write(0), fetch-instruction, data-transfer (owner != 0)
//   BR / BA    bus request out / bus available in
//   DRV_ADDR   per-driver address, driver i at [i*ADDR_W +: ADDR_W]
//   DRV_WDAT   per-driver write data, driver i at [i*DATA_W +: DATA_W]
//   DRV_RDAT   read data registered from D, shared by all drivers
//   DRV_RW, DRV_FI, DRV_RQ  per-driver qualifiers and request (held until OK)
//   DRV_OK     one-hot, one-cycle completion pulse
//   ERR        one-cycle pulse when BA does not arrive in time
//
// Build option
//   BUS_LOCK_EN : adds DRV_LOCK[N_DRV]; a locked owner keeps the bus for up to
//                 LOCK_MAX back-to-back transfers without rearbitration.
// ---------------------------------------------------------------------------
module bus_arbiter_n #(
  parameter int N_DRV      = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int ARB_RR     = 0,
  parameter int BA_TIMEOUT = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  inout  wire  [DATA_W-1:0]       D,
  inout  wire  [ADDR_W-1:0]       A,
  inout  wire                     RW,
  inout  wire                     FI,
  inout  wire                     DT,
  output logic                    BR,
  input  logic                    BA,
  input  logic [N_DRV*ADDR_W-1:0] DRV_ADDR,
  input  logic [N_DRV*DATA_W-1:0] DRV_WDAT,
  output logic [DATA_W-1:0]       DRV_RDAT,
  input  logic [N_DRV-1:0]        DRV_RW,
  input  logic [N_DRV-1:0]        DRV_FI,
  input  logic [N_DRV-1:0]        DRV_RQ,
`ifdef BUS_LOCK_EN
  input  logic [N_DRV-1:0]        DRV_LOCK,
`endif
  output logic [N_DRV-1:0]        DRV_OK,
  output logic                    ERR
);

  import bus_pkg::*;

  localparam int OW = idx_w(N_DRV);
  // A zero timeout still needs a 1-bit counter to keep the declarations legal.
  localparam int TW = (BA_TIMEOUT > 0) ? $clog2(BA_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(BA_TIMEOUT);

  state_t            state, state_nxt;
  logic [OW-1:0]     owner, rr_ptr, pick_idx;
  logic [N_DRV-1:0]  owner_oh, pick_oh;
  logic [TW-1:0]     tmo_cnt;
  logic              owner_ld, err_nxt, tmo_hit, rq_own, xfer_ok, lock_chain;

  logic [ADDR_W-1:0] addr_arr [N_DRV];
  logic [DATA_W-1:0] wdat_arr [N_DRV];
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdat;
  logic              own_rw, own_fi;

  bus_rr_picker #(.N(N_DRV)) u_picker (
    .req     (DRV_RQ),
    .ptr     (rr_ptr),
    .rr_mode (ARB_RR != ARB_FIXED),
    .gnt     (pick_oh),
    .idx     (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < N_DRV; i++) begin
      addr_arr[i] = DRV_ADDR[i*ADDR_W +: ADDR_W];
      wdat_arr[i] = DRV_WDAT[i*DATA_W +: DATA_W];
    end
  end

  assign own_addr = addr_arr[owner];
  assign own_wdat = wdat_arr[owner];
  assign own_rw   = DRV_RW[owner];
  assign own_fi   = DRV_FI[owner];
  assign rq_own   = DRV_RQ[owner];
  assign tmo_hit  = (BA_TIMEOUT != 0) && (tmo_cnt == TMO_MAX);

`ifdef BUS_LOCK_EN
  logic [3:0] lock_cnt;
  // lock_cnt counts transfers already chained; the LOCK_MAX-th one must release.
  assign lock_chain = DRV_LOCK[owner] && (lock_cnt != 4'(LOCK_MAX - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_cnt <= '0;
    end else if ((state == XFER) && (state_nxt == XFER)) begin
      lock_cnt <= lock_cnt + 4'd1;
    end else begin
      lock_cnt <= '0;
    end
  end
`else
  assign lock_chain = 1'b0;
`endif

  // Next-state logic. The owner is frozen from latch until the FSM returns
  // to IDLE, so a late higher-priority request cannot preempt it.
  always_comb begin
    state_nxt = state;
    owner_ld  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (|DRV_RQ) begin
          state_nxt = WAIT_BA;
          owner_ld  = 1'b1;
        end
      end
      WAIT_BA: begin
        if (!rq_own) begin
          state_nxt = IDLE;
        end else if (BA) begin
          state_nxt = XFER;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end
      XFER: begin
        // Losing BA mid-transfer retries with the same owner.
        if (!BA) begin
          state_nxt = WAIT_BA;
        end else if (!(rq_own && lock_chain)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode the registered state; RST masks them so a reset landing
  // on a transfer cycle emits neither OK nor ERR.
  assign xfer_ok = (state == XFER) && BA && rq_own && !RST;
  assign BR      = (state != IDLE) && !RST;
  assign DRV_OK  = xfer_ok ? owner_oh : '0;
  assign ERR     = err_nxt && !RST;

  assign A  = xfer_ok ? own_addr : {ADDR_W{1'bz}};
  assign D  = (xfer_ok && !own_rw) ? own_wdat : {DATA_W{1'bz}};
  assign RW = xfer_ok ? own_rw : 1'bz;
  assign FI = xfer_ok ? own_fi : 1'bz;
  assign DT = xfer_ok ? (owner != '0) : 1'bz;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      owner    <= '0;
      owner_oh <= '0;
      rr_ptr   <= OW'(N_DRV - 1);
      tmo_cnt  <= '0;
      DRV_RDAT <= '0;
    end else begin
      state <= state_nxt;
      if (owner_ld) begin
        owner    <= pick_idx;
        owner_oh <= pick_oh;
      end
      // The pointer moves only when ownership is released, not inside a lock run.
      if (xfer_ok && (state_nxt != XFER)) rr_ptr <= owner;
      if (state == WAIT_BA) begin
        if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      if (xfer_ok && own_rw) DRV_RDAT <= D;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_n
// Directed bench for bus_arbiter_n. Two instances share all inputs: u_fix
// (fixed priority) and u_rr (round-robin), both with BA_TIMEOUT = 4.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_n;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ba  = 1'b0;
  logic [N*AW-1:0] drv_addr = '0;
  logic [N*DW-1:0] drv_wdat = '0;
  logic [N-1:0]    drv_rw   = '0;
  logic [N-1:0]    drv_fi   = '0;
  logic [N-1:0]    drv_rq   = '0;
`ifdef BUS_LOCK_EN
  logic [N-1:0]    drv_lock = '0;
`endif

  wire  [DW-1:0] d_f, d_r;
  wire  [AW-1:0] a_f, a_r;
  wire           rw_f, rw_r, fi_f, fi_r, dt_f, dt_r;
  logic          br_f, br_r, err_f, err_r;
  logic [DW-1:0] rdat_f, rdat_r;
  logic [N-1:0]  ok_f, ok_r;

  logic [DW-1:0] d_tb = '0;
  logic          d_oe = 1'b0;
  assign d_f = d_oe ? d_tb : {DW{1'bz}};
  assign d_r = d_oe ? d_tb : {DW{1'bz}};

  int n_checks = 0;
  int n_errors = 0;

  bus_arbiter_n #(.N_DRV(N), .ADDR_W(AW), .DATA_W(DW), .ARB_RR(0), .BA_TIMEOUT(4)) u_fix (
    .CLK(clk), .RST(rst), .D(d_f), .A(a_f), .RW(rw_f), .FI(fi_f), .DT(dt_f),
    .BR(br_f), .BA(ba), .DRV_ADDR(drv_addr), .DRV_WDAT(drv_wdat), .DRV_RDAT(rdat_f),
    .DRV_RW(drv_rw), .DRV_FI(drv_fi), .DRV_RQ(drv_rq),
`ifdef BUS_LOCK_EN
    .DRV_LOCK(drv_lock),
`endif
    .DRV_OK(ok_f), .ERR(err_f)
  );

  bus_arbiter_n #(.N_DRV(N), .ADDR_W(AW), .DATA_W(DW), .ARB_RR(1), .BA_TIMEOUT(4)) u_rr (
    .CLK(clk), .RST(rst), .D(d_r), .A(a_r), .RW(rw_r), .FI(fi_r), .DT(dt_r),
    .BR(br_r), .BA(ba), .DRV_ADDR(drv_addr), .DRV_WDAT(drv_wdat), .DRV_RDAT(rdat_r),
    .DRV_RW(drv_rw), .DRV_FI(drv_fi), .DRV_RQ(drv_rq),
`ifdef BUS_LOCK_EN
    .DRV_LOCK(drv_lock),
`endif
    .DRV_OK(ok_r), .ERR(err_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ba       = 1'b0;
    drv_addr = '0;
    drv_wdat = '0;
    drv_rw   = '0;
    drv_fi   = '0;
    drv_rq   = '0;
    d_oe     = 1'b0;
    d_tb     = '0;
`ifdef BUS_LOCK_EN
    drv_lock = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] exp_r;
    logic [N-1:0] exp_f;

    // Reset state
    do_reset();
    mid();
    check("rst_br",   br_f,   0);
    check("rst_ok",   ok_f,   0);
    check("rst_err",  err_f,  0);
    check("rst_rdat", rdat_f, 0);
    check("rst_br_rr", br_r,  0);

    // Single write from driver 2
    do_reset();
    ba                  = 1'b1;
    drv_rq              = 4'b0100;
    drv_addr[2*AW +: AW] = 16'h1234;
    drv_wdat[2*DW +: DW] = 8'hA5;
    drv_fi[2]           = 1'b1;
    mid();
    check("wr_br_c0", br_f, 0);
    tick(); mid();
    check("wr_br_c1", br_f, 1);
    check("wr_ok_c1", ok_f, 0);
    tick(); mid();
    check("wr_ok",   ok_f, 4'b0100);
    check("wr_a",    a_f,  16'h1234);
    check("wr_d",    d_f,  8'hA5);
    check("wr_rw",   rw_f, 0);
    check("wr_fi",   fi_f, 1);
    check("wr_dt",   dt_f, 1);
    check("wr_br",   br_f, 1);
    check("wr_ok_rr", ok_r, 4'b0100);
    check("wr_a_rr",  a_r,  16'h1234);
    check("wr_d_rr",  d_r,  8'hA5);
    check("wr_ctl_rr", {29'd0, rw_r, fi_r, dt_r}, 32'b011);
    tick();
    drv_rq = '0;
    mid();
    check("wr_br_done", br_f, 0);
    check("wr_ok_done", ok_f, 0);

    // Fixed priority, requests 1011 held: driver 0 every time
    do_reset();
    ba     = 1'b1;
    drv_rq = 4'b1011;
    for (int c = 0; c < 9; c++) begin
      mid();
      exp_f = (c % 3 == 2) ? 4'b0001 : 4'b0000;
      check($sformatf("fix1011_ok_c%0d", c), ok_f, exp_f);
      tick();
    end

    // All four requesting: round-robin 0,1,2,3,0 vs fixed always 0
    do_reset();
    ba     = 1'b1;
    drv_rq = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      mid();
      exp_r = (c % 3 == 2) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
      exp_f = (c % 3 == 2) ? 4'b0001 : 4'b0000;
      check($sformatf("rr_ok_c%0d", c),  ok_r, exp_r);
      check($sformatf("fix_ok_c%0d", c), ok_f, exp_f);
      tick();
    end

    // BA timeout: counter runs 0..4 across WAIT_BA, ERR when it reaches 4
    do_reset();
    ba     = 1'b0;
    drv_rq = 4'b0010;
    mid();
    check("tmo_br_c0", br_f, 0);
    for (int c = 1; c <= 5; c++) begin
      tick(); mid();
      check($sformatf("tmo_br_c%0d", c),  br_f,  1);
      check($sformatf("tmo_err_c%0d", c), err_f, (c == 5) ? 1 : 0);
      check($sformatf("tmo_ok_c%0d", c),  ok_f,  0);
    end
    check("tmo_err_rr", err_r, 1);
    tick();
    drv_rq = '0;
    mid();
    check("tmo_br_after",  br_f,  0);
    check("tmo_err_after", err_f, 0);

    // Read from driver 0 with BA dropping during the first XFER
    do_reset();
    ba                   = 1'b1;
    drv_rq               = 4'b0001;
    drv_rw[0]            = 1'b1;
    drv_addr[0*AW +: AW] = 16'h0040;
    mid();
    tick(); mid();
    check("rd_br_c1", br_f, 1);
    tick();
    ba = 1'b0;
    mid();
    check("rd_ok_abort", ok_f, 0);
    check("rd_br_abort", br_f, 1);
    tick();
    ba   = 1'b1;
    d_tb = 8'h3C;
    d_oe = 1'b1;
    mid();
    check("rd_ok_wait",   ok_f,   0);
    check("rd_br_wait",   br_f,   1);
    check("rd_rdat_wait", rdat_f, 0);
    tick(); mid();
    check("rd_ok",  ok_f, 4'b0001);
    check("rd_rw",  rw_f, 1);
    check("rd_a",   a_f,  16'h0040);
    check("rd_dt",  dt_f, 0);
    tick();
    drv_rq = '0;
    d_oe   = 1'b0;
    mid();
    check("rd_rdat",    rdat_f, 8'h3C);
    check("rd_rdat_rr", rdat_r, 8'h3C);
    check("rd_ok_done", ok_f,   0);

    // Reset landing on the transfer cycle
    do_reset();
    ba     = 1'b1;
    drv_rq = 4'b0100;
    tick();
    tick();
    rst = 1'b1;
    mid();
    check("rstx_ok",  ok_f,  0);
    check("rstx_err", err_f, 0);
    tick();
    rst    = 1'b0;
    drv_rq = '0;
    mid();
    check("rstx_br", br_f, 0);
    check("rstx_ok_after", ok_f, 0);

`ifdef BUS_LOCK_EN
    // Locked driver 2 keeps the bus for 16 transfers, then driver 0 wins
    do_reset();
    ba       = 1'b1;
    drv_rq   = 4'b0100;
    drv_lock = 4'b0100;
    mid();
    tick();
    drv_rq[0] = 1'b1;
    mid();
    check("lk_br_c1", br_f, 1);
    for (int c = 2; c < 18; c++) begin
      tick(); mid();
      check($sformatf("lk_ok_c%0d", c), ok_f, 4'b0100);
      check($sformatf("lk_br_c%0d", c), br_f, 1);
    end
    tick();
    drv_rq[2] = 1'b0;
    mid();
    check("lk_idle_br", br_f, 0);
    check("lk_idle_ok", ok_f, 0);
    tick(); mid();
    check("lk_wait_br", br_f, 1);
    tick(); mid();
    check("lk_ok0", ok_f, 4'b0001);
    tick();
    drv_rq = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
